// File: rtl/regfl_pkg.sv
// Shared types and defaults for the streaming register file.
// Default entry width / depth and the fill-state encoding live here.
package regfl_pkg;

    localparam int REGFL_W_DEFAULT     = 64;
    localparam int REGFL_DEPTH_DEFAULT = 8;

    // Plain-vector state type so the encoding stays stable for older tooling.
    typedef logic [1:0] regfl_state_t;

    localparam regfl_state_t EMPTY = 2'd0;
    localparam regfl_state_t FILL  = 2'd1;
    localparam regfl_state_t FULL  = 2'd2;

endpackage

// File: rtl/regfl_entry.sv
// One W-bit storage word with load, per-byte enable and asynchronous clear.
module regfl_entry #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           load_i,
    input  logic [W/8-1:0] be_i,
    input  logic [W-1:0]   d_i,
    output logic [W-1:0]   q_o
);

    localparam int NB = W / 8;

    logic [W-1:0] word_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            word_q <= '0;
        end else if (load_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    word_q[b*8 +: 8] <= d_i[b*8 +: 8];
                end
            end
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/regfl_stream.sv
// Register file filled sequentially from a valid/ready stream, with a random-access
// write port on the side. Define REGFL_STREAM_WSTRB_EN to add byte strobes to random writes.
module regfl_stream
    import regfl_pkg::*;
#(
    parameter int  W     = REGFL_W_DEFAULT,
    parameter int  DEPTH = REGFL_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               clr,
    input  logic               we,
    input  logic [AW-1:0]      idx,
    input  logic [W-1:0]       d,
`ifdef REGFL_STREAM_WSTRB_EN
    input  logic [W/8-1:0]     wstrb,
`endif
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W-1:0]       s_data,
    output logic [AW:0]        cnt,
    output logic               full,
    output logic               done,
    output logic [DEPTH*W-1:0] q
);

    localparam int          NB       = W / 8;
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    regfl_state_t  state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          done_q, done_d;

    logic          hs;
    logic [AW-1:0] wr_ptr;
    logic [NB-1:0] rnd_be;

    assign s_ready = (state_q != FULL) && !clr;
    assign hs      = s_valid && s_ready;
    assign wr_ptr  = cnt_q[AW-1:0];

`ifdef REGFL_STREAM_WSTRB_EN
    assign rnd_be = wstrb;
`else
    assign rnd_be = '1;
`endif

    // clr wins over a same-cycle handshake; the stored words are left untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (clr) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else if (hs) begin
            cnt_d = cnt_q + (AW+1)'(1);
            if (cnt_q == CNT_LAST) begin
                state_d = FULL;
                done_d  = 1'b1;
            end else begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = (state_q == FULL);
    assign done = done_q;

    // Stream write takes the whole word and overrides a random write to the same slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic          s_hit;
            logic          r_hit;
            logic          load;
            logic [NB-1:0] be;
            logic [W-1:0]  wdata;
            logic [W-1:0]  ent_q;

            assign s_hit = hs && (wr_ptr == AW'(gi));
            assign r_hit = we && (idx == AW'(gi));
            assign load  = s_hit || r_hit;
            assign be    = s_hit ? {NB{1'b1}} : rnd_be;
            assign wdata = s_hit ? s_data : d;

            regfl_entry #(
                .W (W)
            ) u_entry (
                .clk    (clk),
                .rst_b  (rst_b),
                .load_i (load),
                .be_i   (be),
                .d_i    (wdata),
                .q_o    (ent_q)
            );

            assign q[(DEPTH-1-gi)*W +: W] = ent_q;
        end
    endgenerate

endmodule

// File: doc/regfl_stream.md
REGFL_STREAM -- requirements
Module: regfl_stream

Interface
REQ-001 Parameter: W, default 64, entry width in bits; SHALL be a multiple of 8, at least 8.
REQ-002 Parameter: DEPTH, default 8, number of entries; SHALL be a power of two, at least 2.
REQ-003 Derived localparam: AW = $clog2(DEPTH), index width.
REQ-004 Port: clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 Port: rst_b  in  1  reset, asynchronous, active-low.
REQ-006 Port: clr  in  1  synchronous restart of fill sequence.
REQ-007 Port: we  in  1  random-access write enable.
REQ-008 Port: idx  in  AW  random-access write index.
REQ-009 Port: d  in  W  random-access write data.
REQ-010 Port: s_valid  in  1  stream word valid.
REQ-011 Port: s_ready  out  1  stream word accepted when s_valid is also high.
REQ-012 Port: s_data  in  W  stream word.
REQ-013 Port: cnt  out  AW+1  number of entries filled by the stream, 0..DEPTH.
REQ-014 Port: full  out  1  block complete.
REQ-015 Port: done  out  1  one-cycle pulse on the completing fill.
REQ-016 Port: q  out  DEPTH*W  flat image; entry k SHALL appear at q[(DEPTH-1-k)*W +: W], so entry 0 is the MSB word.

Function
REQ-017 FSM states: EMPTY (cnt=0), FILL (0<cnt<DEPTH), FULL (cnt=DEPTH).
REQ-018 s_ready SHALL equal (state!=FULL) && !clr, combinationally.
REQ-019 On s_valid&&s_ready, s_data SHALL be written to entry cnt[AW-1:0] and cnt SHALL increment by 1.
REQ-020 Transitions: EMPTY->FILL on a handshake; FILL->FULL on the handshake that writes entry DEPTH-1; EMPTY->FULL directly is impossible since DEPTH>=2.
REQ-021 done SHALL be high for exactly the one cycle after the completing handshake; full SHALL be high for the whole time the FSM is in FULL.
REQ-022 clr in any state SHALL force the state to EMPTY and cnt to 0 on the next edge; entry contents SHALL be retained; clr SHALL take precedence over a same-cycle handshake.
REQ-023 Random write (we=1) SHALL write d to entry idx in every state and SHALL NOT change cnt or the state.
REQ-024 If the stream and we target the same entry in one cycle, the stream data SHALL win; different entries SHALL both be written.
REQ-025 Write-to-q latency SHALL be one cycle; there SHALL be no combinational path from d or s_data to q.
REQ-026 In FULL, s_valid SHALL be ignored and no entry SHALL change except through we.

Reset
REQ-027 While rst_b=0: all entries SHALL be 0, state EMPTY, cnt=0, full=0, done=0; q=0. s_ready=1 unless clr=1.
REQ-028 A reset mid-fill SHALL discard progress; the next fill SHALL start at entry 0.

Configuration
REQ-029 With REGFL_STREAM_WSTRB_EN defined: add input wstrb[W/8]; a random write SHALL update only the bytes whose wstrb bit is 1, and the stream path SHALL always write full words.
REQ-030 Without REGFL_STREAM_WSTRB_EN: no wstrb port; random writes SHALL update the full word.

Structure
REQ-031 Package regfl_pkg SHALL hold the FSM state typedef (EMPTY/FILL/FULL) and the default W/DEPTH constants.
REQ-032 The per-entry storage SHALL be one sub-module, regfl_entry (W-bit register with load, byte-enable and async reset), instantiated DEPTH times by a generate loop.

Verification
REQ-033 Reset, then 8 handshakes with s_data=0x11..11*k, k=1..8 -> cnt=8, full=1, done high for exactly 1 cycle, q[511:448]=0x1111111111111111.
REQ-034 Hold s_valid low for 3 cycles mid-fill after 4 words -> cnt stays 4 and s_ready stays 1; fill then resumes at entry 4.
REQ-035 In FULL, s_valid=1 with s_data=0xDEAD -> s_ready=0, q unchanged; then clr=1 -> state EMPTY, cnt=0, q unchanged.
REQ-036 At cnt=2, assert we with idx=2 and d=0xAA alongside a stream word 0xBB -> entry 2=0xBB; we with idx=5 alongside a stream word -> entry 2=stream word, entry 5=0xAA.
REQ-037 Drop rst_b asynchronously at cnt=5 between clock edges -> q=0 and cnt=0 immediately, before the next edge.
REQ-038 Only with REGFL_STREAM_WSTRB_EN: entry 3=0xFFFF_FFFF_FFFF_FFFF, then we with wstrb=8'h0F and d=0 -> entry 3=0xFFFF_FFFF_0000_0000.
